// File: rtl/music_pkg.sv
// ============================================================================
// music_pkg: shared states and sizing for the music controller.  Rev 1.0
// ============================================================================
`default_nettype none

package music_pkg;

   localparam int NUM_SLOTS         = 16;
   localparam int ADDR_W            = 4;
   localparam int TEMPO_DIV_DEFAULT = 25_000_000;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      REC_LOAD  = 3'd1,
      REC_HOLD  = 3'd2,
      REC_REL   = 3'd3,
      PLAY_STEP = 3'd4,
      PLAY_WAIT = 3'd5,
      RESTORE   = 3'd6
   } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/note_sequencer_tempo_timer.sv
// ============================================================================
// tempo_timer: tick after TEMPO_DIV-1 enabled counts following clear.  Rev 1.0
// ============================================================================
`default_nettype none

module tempo_timer #(
   parameter int TEMPO_DIV = music_pkg::TEMPO_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(TEMPO_DIV);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TEMPO_DIV - 2);

   logic [CNT_W-1:0] count;

   // Holds at the terminal value rather than wrapping; the controller clears it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != TERMINAL)) begin
         count <= count + 1'b1;
      end
   end

   assign tick = enable && (count == TERMINAL);

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// note_sequencer: record/play/stop key controller for the music datapath.
// Optional LOOP_PLAY_EN makes playback repeat until stop.  Rev 1.0
// ============================================================================
`default_nettype none

module note_sequencer #(
   parameter int TEMPO_DIV = music_pkg::TEMPO_DIV_DEFAULT,
   parameter int NUM_SLOTS = music_pkg::NUM_SLOTS
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        record_key,
   input  logic                        play_key,
   input  logic                        stop_key,
   output logic                        ld_note,
   output logic                        ld_play,
   output logic [music_pkg::ADDR_W-1:0] note_counter,
   output logic                        next_note_en,
   output logic                        display_note,
   output logic                        playing,
   output logic [music_pkg::ADDR_W:0]   notes_stored
);

   import music_pkg::*;

   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(NUM_SLOTS);

   seq_state_t state;
   logic       rec_q;
   logic       play_q;
   logic       stop_q;
   logic       rec_press;
   logic       play_press;
   logic       stop_press;
   logic       tick;
   logic       last_note;

   assign rec_press  = record_key & ~rec_q;
   assign play_press = play_key   & ~play_q;
   assign stop_press = stop_key   & ~stop_q;
   assign last_note  = ({1'b0, note_counter} + 1'b1) >= notes_stored;

   tempo_timer #(
      .TEMPO_DIV (TEMPO_DIV)
   ) u_tempo_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (state == PLAY_STEP),
      .enable (state == PLAY_WAIT),
      .tick   (tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         rec_q        <= 1'b0;
         play_q       <= 1'b0;
         stop_q       <= 1'b0;
         ld_note      <= 1'b0;
         ld_play      <= 1'b0;
         note_counter <= '0;
         next_note_en <= 1'b0;
         display_note <= 1'b0;
         playing      <= 1'b0;
         notes_stored <= '0;
      end else begin
         rec_q        <= record_key;
         play_q       <= play_key;
         stop_q       <= stop_key;
         ld_note      <= 1'b0;
         next_note_en <= 1'b0;

         case (state)
            IDLE: begin
               // A higher-priority press that is not actionable still masks lower ones.
               if (stop_press) begin
                  state <= IDLE;
               end else if (play_press) begin
                  if (notes_stored != '0) begin
                     state        <= PLAY_STEP;
                     ld_play      <= 1'b1;
                     next_note_en <= 1'b1;
                     note_counter <= '0;
                     display_note <= 1'b1;
                     playing      <= 1'b1;
                  end
               end else if (rec_press && (notes_stored < FULL_COUNT)) begin
                  state   <= REC_LOAD;
                  ld_note <= 1'b1;
               end
            end

            REC_LOAD: begin
               state   <= REC_HOLD;
               ld_note <= 1'b1;
            end

            REC_HOLD: begin
               state        <= REC_REL;
               notes_stored <= notes_stored + 1'b1;
            end

            REC_REL: begin
               if (!record_key) begin
                  state <= IDLE;
               end
            end

            PLAY_STEP, PLAY_WAIT: begin
               if (stop_press) begin
                  state        <= RESTORE;
                  note_counter <= notes_stored[ADDR_W-1:0];
               end else if (state == PLAY_STEP) begin
                  state <= PLAY_WAIT;
               end else if (tick) begin
                  if (!last_note) begin
                     state        <= PLAY_STEP;
                     note_counter <= note_counter + 1'b1;
                     next_note_en <= 1'b1;
                  end else begin
`ifdef LOOP_PLAY_EN
                     state        <= PLAY_STEP;
                     note_counter <= '0;
                     next_note_en <= 1'b1;
`else
                     state        <= RESTORE;
                     note_counter <= notes_stored[ADDR_W-1:0];
`endif
                  end
               end
            end

            RESTORE: begin
               state        <= IDLE;
               ld_play      <= 1'b0;
               note_counter <= '0;
               display_note <= 1'b0;
               playing      <= 1'b0;
            end

            default: begin
               state        <= IDLE;
               ld_play      <= 1'b0;
               note_counter <= '0;
               display_note <= 1'b0;
               playing      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: doc/note_sequencer.md
# note_sequencer

Control FSM for the music datapath: turns debounced record/play/stop keys into the `ld_note`, `ld_play`, `note_counter` and `next_note_en` strobes the datapath expects. It sits between the board key inputs and the datapath and owns the recorded-note count, the playback tempo and the write-pointer realignment after playback.

## Interface

Parameters:
- `TEMPO_DIV`, default 25_000_000: clk cycles per played note (0.5 s at 50 MHz); legal range ≥ 2.
- `NUM_SLOTS`, default 16: note memory depth; fixed by the 4-bit address.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `record_key`  in  1  active-high level, debounced and synchronous to `clk`.
- `play_key`  in  1  active-high level, debounced and synchronous to `clk`.
- `stop_key`  in  1  active-high level, debounced and synchronous to `clk`.
- `ld_note`  out  1  datapath write strobe.
- `ld_play`  out  1  datapath read/address-load strobe.
- `note_counter`  out  4  datapath read address, or write-pointer restore value.
- `next_note_en`  out  1  one-cycle pulse per played note, to the VGA path.
- `display_note`  out  1  high for the whole of playback.
- `playing`  out  1  status: controller is in a play state.
- `notes_stored`  out  5  count of recorded notes, 0..16.

## Operation

- Edge detection: one registered copy of each key. "Press" means the key is high this cycle and was low last cycle.
- Priority among presses in the same cycle: stop > play > record.
- States:
  - IDLE:
    - record press with `notes_stored` < 16 → REC_LOAD.
    - play press with `notes_stored` ≠ 0 → PLAY_STEP, `note_counter`=0.
    - All other presses are ignored, including record when full and play when empty.
  - REC_LOAD: `ld_note`=1 → REC_HOLD.
  - REC_HOLD: `ld_note`=1, `notes_stored` increments → REC_REL.
  - REC_REL: `ld_note`=0. The datapath advances its write address on this cycle. Wait until `record_key` is low → IDLE.
  - The record sequence is atomic: stop and play are ignored in REC_LOAD, REC_HOLD and REC_REL.
  - PLAY_STEP: `ld_play`=1, `next_note_en`=1 for one cycle, tempo counter cleared → PLAY_WAIT.
  - PLAY_WAIT: `ld_play`=1; tempo counter counts up to `TEMPO_DIV`-2.
    - On terminal count with `note_counter` < `notes_stored`-1: increment `note_counter` → PLAY_STEP.
    - On terminal count at the last stored note → end-of-sequence handling (see Configuration).
  - RESTORE: `ld_play`=1, `note_counter`=`notes_stored[3:0]` for exactly one cycle → IDLE. This realigns the datapath write address to the next free slot. When full, the value is 0; this is harmless because recording is blocked.
  - A stop press in PLAY_STEP or PLAY_WAIT → RESTORE on the next cycle.
- `display_note` and `playing` are 1 in PLAY_STEP, PLAY_WAIT and RESTORE; 0 elsewhere.
- `notes_stored` saturates at 16. Only `reset` clears it.

## Timing

- All outputs are registered.
- Reset values: state IDLE, all outputs 0, tempo counter 0, key history 0.
- Record latency: press at cycle n → `ld_note` high in cycles n+1 and n+2, low in n+3. `notes_stored` updates at the end of n+2.
- Play latency: press at cycle n → `ld_play` and `next_note_en` high in n+1. The datapath memory read appears about 2 cycles later.
- Note period: exactly `TEMPO_DIV` cycles between consecutive `next_note_en` pulses.
- Tempo counter width: clog2(`TEMPO_DIV`); it is cleared on every PLAY_STEP and never wraps on its own.
- `reset` asserted mid-sequence: immediate return to IDLE with outputs 0. Stored data in the datapath is not controller-owned; the datapath resets itself.

## Configuration

- `LOOP_PLAY_EN` defined: at the last stored note, PLAY_WAIT terminal count sets `note_counter` to 0 and goes to PLAY_STEP. Playback repeats until a stop press.
- `LOOP_PLAY_EN` undefined: at the last stored note, PLAY_WAIT terminal count goes to RESTORE. Playback is one-shot.

## Structure

- Shared package `music_pkg` holds:
  - the state enum;
  - `NUM_SLOTS`=16;
  - `ADDR_W`=4;
  - the `TEMPO_DIV` default constant.
- One sub-module, `tempo_timer`:
  - inputs `clear` and `enable`; output `tick`, one cycle at `TEMPO_DIV`-1 counts after `clear`;
  - parameterised by `TEMPO_DIV`.

## Test plan

Benches use `TEMPO_DIV`=4.

- Reset, then three record presses, each held 5 cycles → three 2-cycle `ld_note` pulses; `notes_stored`=3; `ld_play` stays 0.
- With 3 notes stored, press play (loop off) → `next_note_en` pulses 4 cycles apart with `note_counter` 0,1,2; then a RESTORE cycle with `note_counter`=3; then IDLE with `playing`=0.
- 16 record presses, then a 17th → 16 `ld_note` pulses, 17th ignored; `notes_stored`=16. Play with loop on → `note_counter` runs 0..15 then wraps to 0.
- Stop press 2 cycles into PLAY_WAIT on note 1 → next cycle RESTORE with `note_counter`=`notes_stored`; no further `next_note_en`.
- Record and play pressed in the same cycle with 2 notes stored → playback starts, no `ld_note`. Play press with 0 stored → no response.
- `reset` asserted during REC_HOLD and again during PLAY_WAIT → all outputs 0 immediately; `notes_stored`=0.
